// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between NB_REQ requesters.
// One access per cycle, 1-cycle read latency, saturating read/write bandwidth counters.
module ext_mem_arbiter #(
  parameter int unsigned NB_REQ     = 3,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         arst_in,
  input  logic                         grant_en,
  input  logic [NB_REQ-1:0]            req_valid,
  input  logic [NB_REQ-1:0]            req_write,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NB_REQ-1:0]            req_ready,
  output logic [NB_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ADDR_WIDTH-1:0]        ext_mem_read_addr,
  output logic                         ext_mem_read_en,
  input  logic [DATA_WIDTH-1:0]        ext_mem_qout,
  output logic [ADDR_WIDTH-1:0]        ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0]        ext_mem_din,
  output logic                         ext_mem_write_en,
  input  logic                         clear_counters,
  output logic [CNT_WIDTH-1:0]         read_count,
  output logic [CNT_WIDTH-1:0]         write_count,
  output logic                         busy
);

  localparam int unsigned PtrW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NB_REQ - 1);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       gnt_idx, scan_idx;
  logic                  gnt_found, accept, acc_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rsp_pend_q;
  logic [PtrW-1:0]       rsp_id_q;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, wr_cnt_q;

  // First valid requester at or after ptr, wrapping modulo NB_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = ptr_q;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LastIdx) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    acc_write = 1'b0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        acc_write = req_write[i];
      end
    end
  end

  assign accept = grant_en && gnt_found;

  always_comb begin
    req_ready          = '0;
    ext_mem_read_en    = 1'b0;
    ext_mem_read_addr  = '0;
    ext_mem_write_en   = 1'b0;
    ext_mem_write_addr = '0;
    ext_mem_din        = '0;
    rsp_valid          = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
      if (acc_write) begin
        ext_mem_write_en   = 1'b1;
        ext_mem_write_addr = sel_addr;
        ext_mem_din        = sel_wdata;
      end else begin
        ext_mem_read_en   = 1'b1;
        ext_mem_read_addr = sel_addr;
      end
    end
    if (rsp_pend_q) begin
      rsp_valid[rsp_id_q] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      ptr_q      <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rsp_pend_q <= ext_mem_read_en;
      if (ext_mem_read_en) begin
        rsp_id_q <= gnt_idx;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (clear_counters) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (ext_mem_read_en && (rd_cnt_q != {CNT_WIDTH{1'b1}})) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      if (ext_mem_write_en && (wr_cnt_q != {CNT_WIDTH{1'b1}})) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  assign rsp_data    = ext_mem_qout;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
  assign busy        = accept || rsp_pend_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Scoreboard bench for ext_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of round-robin arbitration, memory contents and counters.
module tb_ext_mem_arbiter;

  localparam int NB   = 3;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic             clk = 1'b0;
  logic             arst_in;
  logic             grant_en;
  logic [NB-1:0]    req_valid;
  logic [NB-1:0]    req_write;
  logic [NB*AW-1:0] req_addr;
  logic [NB*DW-1:0] req_wdata;
  logic [NB-1:0]    req_ready;
  logic [NB-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [AW-1:0]    ext_mem_read_addr;
  logic             ext_mem_read_en;
  logic [DW-1:0]    ext_mem_qout;
  logic [AW-1:0]    ext_mem_write_addr;
  logic [DW-1:0]    ext_mem_din;
  logic             ext_mem_write_en;
  logic             clear_counters;
  logic [CW-1:0]    read_count;
  logic [CW-1:0]    write_count;
  logic             busy;

  always #5 clk = ~clk;

  ext_mem_arbiter #(
    .NB_REQ    (NB),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .arst_in           (arst_in),
    .grant_en          (grant_en),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .ext_mem_read_addr (ext_mem_read_addr),
    .ext_mem_read_en   (ext_mem_read_en),
    .ext_mem_qout      (ext_mem_qout),
    .ext_mem_write_addr(ext_mem_write_addr),
    .ext_mem_din       (ext_mem_din),
    .ext_mem_write_en  (ext_mem_write_en),
    .clear_counters    (clear_counters),
    .read_count        (read_count),
    .write_count       (write_count),
    .busy              (busy)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // External memory: 256 words aliased on the low address byte, 1-cycle read.
  logic [DW-1:0] mem [256];
  bit            mem_inited;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_inited <= 1'b1;
    end else begin
      if (ext_mem_read_en) ext_mem_qout <= mem[ext_mem_read_addr[7:0]];
      if (ext_mem_write_en) mem[ext_mem_write_addr[7:0]] <= ext_mem_din;
    end
  end

  typedef struct {
    logic [NB-1:0] ready;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic [CW-1:0] rc;
    logic [CW-1:0] wc;
    logic          busy;
  } cyc_exp_t;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_exp_t;

  cyc_exp_t grant_q[$];
  rsp_exp_t rsp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  int            m_ptr, m_rd, m_wr;
  logic [DW-1:0] ref_mem [256];

  // Requester-side stimulus state
  logic [NB-1:0] r_valid, r_write;
  logic [AW-1:0] r_addr  [NB];
  logic [DW-1:0] r_wdata [NB];
  logic          ge_t, clr_t, arst_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    r_valid[i] = 1'b1;
    r_write[i] = w;
    r_addr[i]  = a;
    r_wdata[i] = d;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step();
    int       g;
    int       idx;
    cyc_exp_t e;
    rsp_exp_t r;
    @(posedge clk);
    #1;
    cyc++;
    arst_in        = arst_t;
    grant_en       = ge_t;
    clear_counters = clr_t;
    for (int i = 0; i < NB; i++) begin
      req_valid[i]            = arst_t ? 1'b0 : r_valid[i];
      req_write[i]            = r_write[i];
      req_addr[i*AW +: AW]    = r_addr[i];
      req_wdata[i*DW +: DW]   = r_wdata[i];
    end
    e = '{default: '0};
    if (arst_t) begin
      m_ptr = 0;
      m_rd  = 0;
      m_wr  = 0;
      rsp_q.delete();
      grant_q.push_back(e);
      return;
    end
    e.rc = CW'(m_rd);
    e.wc = CW'(m_wr);
    g = -1;
    if (ge_t) begin
      for (int k = 0; k < NB; k++) begin
        idx = (m_ptr + k) % NB;
        if (g < 0 && r_valid[idx]) g = idx;
      end
    end
    e.busy = (g >= 0) || (rsp_q.size() > 0 && rsp_q[0].due == cyc);
    if (g >= 0) begin
      e.ready[g] = 1'b1;
      if (r_write[g]) begin
        e.wr_en = 1'b1;
        e.waddr = r_addr[g];
        e.din   = r_wdata[g];
        ref_mem[r_addr[g][7:0]] = r_wdata[g];
        if (m_wr < CMAX) m_wr++;
      end else begin
        e.rd_en = 1'b1;
        e.raddr = r_addr[g];
        r.due   = cyc + 1;
        r.id    = g;
        r.data  = ref_mem[r_addr[g][7:0]];
        rsp_q.push_back(r);
        if (m_rd < CMAX) m_rd++;
      end
      m_ptr      = (g + 1) % NB;
      r_valid[g] = 1'b0;
    end
    if (clr_t) begin
      m_rd = 0;
      m_wr = 0;
    end
    grant_q.push_back(e);
  endtask

  // Monitor: compares every cycle's outputs against the queued predictions.
  cyc_exp_t      mon_e;
  rsp_exp_t      mon_r;
  logic [NB-1:0] mon_rv;
  always @(negedge clk) begin
    if (grant_q.size() > 0) begin
      mon_e = grant_q.pop_front();
      chk("req_ready", 64'(req_ready), 64'(mon_e.ready));
      chk("read_en", 64'(ext_mem_read_en), 64'(mon_e.rd_en));
      chk("write_en", 64'(ext_mem_write_en), 64'(mon_e.wr_en));
      chk("read_addr", 64'(ext_mem_read_addr), 64'(mon_e.raddr));
      chk("write_addr", 64'(ext_mem_write_addr), 64'(mon_e.waddr));
      chk("din", 64'(ext_mem_din), 64'(mon_e.din));
      chk("read_count", 64'(read_count), 64'(mon_e.rc));
      chk("write_count", 64'(write_count), 64'(mon_e.wc));
      chk("busy", 64'(busy), 64'(mon_e.busy));
      mon_rv = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        mon_r = rsp_q.pop_front();
        mon_rv[mon_r.id] = 1'b1;
        chk("rsp_data", 64'(rsp_data), 64'(mon_r.data));
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(mon_rv));
    end
  end

  initial begin
    arst_in        = 1'b1;
    grant_en       = 1'b0;
    clear_counters = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    r_valid        = '0;
    r_write        = '0;
    for (int i = 0; i < NB; i++) begin
      r_addr[i]  = '0;
      r_wdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_ptr  = 0;
    m_rd   = 0;
    m_wr   = 0;
    ge_t   = 1'b1;
    clr_t  = 1'b0;
    arst_t = 1'b1;
    step();
    step();
    arst_t = 1'b0;

    // Single read of a preloaded word
    set_req(1, 1'b0, 20'h00010, '0);
    step();
    step();
    step();

    // Contested continuous reads from a fresh pointer
    arst_t = 1'b1;
    step();
    arst_t = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NB; i++) if (!r_valid[i]) set_req(i, 1'b0, AW'($urandom), '0);
      step();
    end
    r_valid = '0;
    step();

    // Move pointer to 2, then write by 2 and read-back by 0 of the same word
    set_req(1, 1'b0, 20'h00030, '0);
    step();
    set_req(2, 1'b1, 20'h00020, 32'h12345678);
    set_req(0, 1'b0, 20'h00020, '0);
    step();
    step();
    step();

    // Grants disabled right after a read acceptance
    set_req(0, 1'b0, AW'($urandom), '0);
    step();
    ge_t = 1'b0;
    for (int i = 0; i < NB; i++) set_req(i, i[0], AW'($urandom), $urandom);
    repeat (4) step();
    ge_t = 1'b1;
    repeat (4) step();

    // Clear beats same-cycle increment, then saturate both counters
    set_req(1, 1'b0, AW'($urandom), '0);
    clr_t = 1'b1;
    step();
    clr_t = 1'b0;
    step();
    for (int c = 0; c < 17; c++) begin
      set_req(0, 1'b0, AW'($urandom), '0);
      step();
    end
    for (int c = 0; c < 17; c++) begin
      set_req(2, 1'b1, AW'($urandom), $urandom);
      step();
    end
    step();

    // Reset in the cycle after a read acceptance drops the response and rewinds ptr
    set_req(2, 1'b0, AW'($urandom), '0);
    step();
    arst_t  = 1'b1;
    r_valid = '0;
    step();
    arst_t = 1'b0;
    for (int i = 0; i < NB; i++) set_req(i, 1'b0, AW'($urandom), '0);
    repeat (4) step();

    // Random traffic
    repeat (300) begin
      for (int i = 0; i < NB; i++) begin
        if (!r_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
      ge_t  = ($urandom_range(0, 7) != 0);
      clr_t = ($urandom_range(0, 31) == 0);
      step();
    end
    ge_t    = 1'b1;
    clr_t   = 1'b0;
    r_valid = '0;
    repeat (3) step();
    @(negedge clk);
    #1;
    chk("rsp_drained", 64'(rsp_q.size()), 64'd0);
    chk("grant_drained", 64'(grant_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
